// File: rtl/sw_ram_writer_if.sv
// sw_ram_writer_if: request/response bundle between the switch-driven controller and the RAM writer
interface sw_ram_writer_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
);
  logic                  wr_req;
  logic                  rd_req;
  logic                  fill_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] fill_idx;
  modport master (
    output wr_req, rd_req, fill_req, addr, wdata,
    input  rdata, busy, done, fill_idx
  );
  modport slave (
    input  wr_req, rd_req, fill_req, addr, wdata,
    output rdata, busy, done, fill_idx
  );
endinterface

// File: rtl/sw_ram_writer.sv
// sw_ram_writer: small RAM with single write, single read and incrementing-pattern fill operations
module sw_ram_writer #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input logic             clk_2,
  input logic             reset,
  sw_ram_writer_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] FILL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, fill_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:        state_d = bus.fill_req ? FILL : bus.wr_req ? WRITE : bus.rd_req ? READ : IDLE;
      WRITE, READ: state_d = DONE;
      FILL:        state_d = (fill_idx_q == LAST) ? DONE : FILL;
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_idx_q <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      if (state_q == IDLE) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state_q == WRITE) mem_q[addr_q] <= wdata_q;
      if (state_q == READ) rdata_q <= mem_q[addr_q];
      if (state_q == FILL) begin
        mem_q[fill_idx_q] <= wdata_q + DATA_WIDTH'(fill_idx_q);
        fill_idx_q        <= fill_idx_q + 1'b1;
      end
    end
  end
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fill_idx = fill_idx_q;
endmodule

// File: tb/tb_sw_ram_writer.sv
// tb_sw_ram_writer: directed checks of reset, write/read latency, fill wrap, priority, busy rejection and mid-fill reset
module tb_sw_ram_writer;
  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;
  always #5 clk = ~clk;
  sw_ram_writer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) bus ();
  sw_ram_writer #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (.clk_2(clk), .reset(reset), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_read(input logic [1:0] a, input logic [3:0] exp);
    bus.rd_req = 1'b1;
    bus.addr   = a;
    tick();
    bus.rd_req = 1'b0;
    bus.addr   = ~a;
    chk("rd_busy", 8'(bus.busy), 8'd1);
    chk("rd_done_early", 8'(bus.done), 8'd0);
    tick();
    chk("rd_done", 8'(bus.done), 8'd1);
    chk($sformatf("rd_data[%0d]", a), 8'(bus.rdata), 8'(exp));
    tick();
    chk("rd_idle", 8'({bus.busy, bus.done}), 8'd0);
  endtask
  task automatic run_fill(input logic [3:0] seed);
    tick();
    bus.fill_req = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
    bus.wdata    = ~seed;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fill_busy", 8'(bus.busy), 8'd1);
      chk("fill_done", 8'(bus.done), 8'(i == 4));
      chk("fill_idx", 8'(bus.fill_idx), 8'(i % 4));
    end
    tick();
    chk("fill_idle", 8'({bus.busy, bus.done}), 8'd0);
  endtask
  initial begin
    logic [3:0] exp_e [4];
    exp_e = '{4'hE, 4'hF, 4'h0, 4'h1};
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.fill_req = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_rdata", 8'(bus.rdata), 8'd0);
    chk("rst_fill_idx", 8'(bus.fill_idx), 8'd0);
    for (int a = 0; a < 4; a++) do_read(2'(a), 4'h0);
    bus.wr_req = 1'b1; bus.addr = 2'd2; bus.wdata = 4'b1001;
    tick();
    bus.wr_req = 1'b0; bus.addr = 2'd1; bus.wdata = 4'h0;
    chk("wr_busy", 8'(bus.busy), 8'd1);
    chk("wr_done_early", 8'(bus.done), 8'd0);
    tick();
    chk("wr_done", 8'(bus.done), 8'd1);
    tick();
    chk("wr_idle", 8'({bus.busy, bus.done}), 8'd0);
    do_read(2'd2, 4'b1001);
    do_read(2'd1, 4'h0);
    bus.fill_req = 1'b1; bus.wdata = 4'hE;
    run_fill(4'hE);
    for (int a = 0; a < 4; a++) do_read(2'(a), exp_e[a]);
    bus.fill_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    bus.addr = 2'd1; bus.wdata = 4'h3;
    run_fill(4'h3);
    chk("prio_no_read", 8'(bus.rdata), 8'h1);
    for (int a = 0; a < 4; a++) do_read(2'(a), 4'(3 + a));
    bus.fill_req = 1'b1; bus.wdata = 4'h8;
    tick();
    bus.fill_req = 1'b0;
    tick();
    bus.wr_req = 1'b1; bus.addr = 2'd0; bus.wdata = 4'hF;
    tick();
    bus.wr_req = 1'b0;
    tick(); tick();
    chk("busy_rej_done", 8'(bus.done), 8'd1);
    tick();
    chk("busy_rej_idle", 8'(bus.busy), 8'd0);
    do_read(2'd0, 4'h8);
    do_read(2'd1, 4'h9);
    bus.fill_req = 1'b1; bus.wdata = 4'h5;
    tick();
    bus.fill_req = 1'b0;
    tick(); tick();
    chk("midfill_busy", 8'(bus.busy), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 8'(bus.busy), 8'd0);
    chk("midrst_done", 8'(bus.done), 8'd0);
    chk("midrst_fill_idx", 8'(bus.fill_idx), 8'd0);
    chk("midrst_rdata", 8'(bus.rdata), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_done", 8'({bus.busy, bus.done}), 8'd0);
    end
    for (int a = 0; a < 4; a++) do_read(2'(a), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
